// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake into the
// IF/ID register, with a one-entry skid buffer for stalls and redirect draining.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   drain_addr;
    logic [XLEN-1:0]   redirect_tgt;
    logic              skid_valid;
    logic [XLEN-1:0]   skid_pc;
    logic [XLEN-1:0]   skid_instr;
    logic              fetch_ack;

    assign pc_plus4     = pc + XLEN'(4);
    assign redirect_tgt = redirect_pc_i & ~XLEN'(3);
    assign fetch_ack    = (state == FETCH) && imem_ack_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; redirect outranks stall and ack
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (redirect_i) begin
                    state_nxt = imem_ack_i ? FETCH : DRAIN;
                end else if (imem_ack_i && stall_i) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_i || !stall_i) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack_i) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Memory request outputs; request is dropped immediately under reset
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = pc;
                end
                DRAIN: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = drain_addr;
                end
                default: begin
                    imem_req_o  = 1'b0;
                    imem_addr_o = pc;
                end
            endcase
        end
    end

    // PC and drain address
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else if (redirect_i) begin
            pc <= redirect_tgt;
            if (state == FETCH && !imem_ack_i) begin
                drain_addr <= pc;
            end
        end else if (fetch_ack) begin
            pc <= pc_plus4;
        end
    end

    // Skid buffer catches an instruction returned while decode is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (redirect_i) begin
            skid_valid <= 1'b0;
        end else if (fetch_ack && stall_i) begin
            skid_valid <= 1'b1;
            skid_pc    <= pc;
            skid_instr <= imem_rdata_i;
        end else if (state == HOLD && !stall_i) begin
            skid_valid <= 1'b0;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
            ifid_instr_o <= '0;
        end else if (redirect_i) begin
            ifid_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (fetch_ack) begin
                ifid_valid_o <= 1'b1;
                ifid_pc_o    <= pc;
                ifid_pc4_o   <= pc_plus4;
                ifid_instr_o <= imem_rdata_i;
            end else if (state == HOLD) begin
                ifid_valid_o <= skid_valid;
                ifid_pc_o    <= skid_pc;
                ifid_pc4_o   <= skid_pc + XLEN'(4);
                ifid_instr_o <= skid_instr;
            end else begin
                ifid_valid_o <= 1'b0;
            end
        end
    end

endmodule
